// File: rtl/inst_mem_loader.sv
// inst_mem_loader: packs a big-endian byte stream into 32-bit words and issues
// single-cycle write strobes into the OS or program instruction bank.
// Optional build macro LOADER_CHECKSUM_EN appends a 4-byte checksum phase
// (sum of all data words mod 2^32) after the last data word.
module inst_mem_loader #(
  parameter int MEM_DEPTH = 2049,
  parameter int CNT_W     = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             target_os,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             abort,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             gravar_D,
  output logic             write_os,
  output logic [31:0]      write_address,
  output logic [31:0]      data_write,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t           state_q;
  logic             byte_ready_q;
  logic             gravar_q;
  logic             write_os_q;
  logic [31:0]      write_address_q;
  logic [31:0]      data_write_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic [31:0]      base_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx_q;
  logic [1:0]       bcnt_q;
  logic [23:0]      shift_q;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]      sum_q;
  logic             csum_phase_q;
`endif

  logic [32:0]      end_addr_d;
  logic             range_err_d;
  logic             take_d;
  logic [31:0]      word_d;
  logic [CNT_W-1:0] idx_d;
  logic             last_d;

  // Range check at 33 bits so base_addr near 2^32 cannot wrap into range.
  assign end_addr_d  = {1'b0, base_addr} + {{(33-CNT_W){1'b0}}, word_count};
  assign range_err_d = end_addr_d > 33'(MEM_DEPTH);
  assign take_d      = byte_valid && byte_ready_q;
  assign word_d      = {shift_q, byte_in};
  assign idx_d       = idx_q + 1'b1;
  assign last_d      = (idx_d == cnt_q);

  // Loader FSM; every output is registered together with the state it belongs to.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      byte_ready_q    <= 1'b0;
      gravar_q        <= 1'b0;
      write_os_q      <= 1'b0;
      write_address_q <= '0;
      data_write_q    <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
      base_q          <= '0;
      cnt_q           <= '0;
      idx_q           <= '0;
      bcnt_q          <= '0;
      shift_q         <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q           <= '0;
      csum_phase_q    <= 1'b0;
`endif
    end else begin
      gravar_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            write_os_q <= target_os;
            base_q     <= base_addr;
            cnt_q      <= word_count;
            idx_q      <= '0;
            bcnt_q     <= '0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
            csum_phase_q <= (word_count == '0);
`endif
            if (word_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
              // Empty load still carries a checksum word that must be zero.
              state_q      <= RECV;
              byte_ready_q <= 1'b1;
              busy_q       <= 1'b1;
`else
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b1;
`endif
            end else if (range_err_d) begin
              error_q <= 1'b1;
            end else begin
              state_q      <= RECV;
              byte_ready_q <= 1'b1;
              busy_q       <= 1'b1;
            end
          end
        end
        RECV: begin
          if (abort) begin
            // Partially packed word is simply dropped.
            state_q      <= IDLE;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
          end else if (take_d) begin
            shift_q <= word_d[23:0];
            bcnt_q  <= bcnt_q + 1'b1;
            if (bcnt_q == 2'd3) begin
              byte_ready_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
              if (csum_phase_q) begin
                if (word_d == sum_q) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= IDLE;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                end
              end else begin
                state_q         <= WRITE;
                gravar_q        <= 1'b1;
                write_address_q <= base_q + {{(32-CNT_W){1'b0}}, idx_q};
                data_write_q    <= word_d;
                sum_q           <= sum_q + word_d;
              end
`else
              state_q         <= WRITE;
              gravar_q        <= 1'b1;
              write_address_q <= base_q + {{(32-CNT_W){1'b0}}, idx_q};
              data_write_q    <= word_d;
`endif
            end
          end
        end
        WRITE: begin
          // The strobe for this cycle was already registered; abort only stops what follows.
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (last_d) begin
`ifdef LOADER_CHECKSUM_EN
            state_q      <= RECV;
            csum_phase_q <= 1'b1;
            byte_ready_q <= 1'b1;
`else
            state_q <= DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            idx_q        <= idx_d;
            state_q      <= RECV;
            byte_ready_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          byte_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready    = byte_ready_q;
  assign gravar_D      = gravar_q;
  assign write_os      = write_os_q;
  assign write_address = write_address_q;
  assign data_write    = data_write_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader (default and checksum builds).
module tb_inst_mem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        target_os;
  logic [31:0] base_addr;
  logic [11:0] word_count;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        gravar_D;
  logic        write_os;
  logic [31:0] write_address;
  logic [31:0] data_write;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  int nwr   = 0;
  int ndone = 0;
  int wr0;
  int dn0;

  inst_mem_loader #(.MEM_DEPTH(2049), .CNT_W(12)) dut (
    .clock(clock), .reset(reset), .start(start), .target_os(target_os),
    .base_addr(base_addr), .word_count(word_count), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .gravar_D(gravar_D), .write_os(write_os), .write_address(write_address),
    .data_write(data_write), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Strobe and done-pulse counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (gravar_D) nwr = nwr + 1;
    if (done) ndone = ndone + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("ready_timeout", {31'b0, byte_ready}, 32'd1);
    step();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_start(input logic os, input logic [31:0] ba, input logic [11:0] wc);
    target_os  = os;
    base_addr  = ba;
    word_count = wc;
    start      = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_strobe(input string tag, input logic [31:0] a, input logic [31:0] d, input logic os);
    chk({tag, "_gravar"}, {31'b0, gravar_D}, 32'd1);
    chk({tag, "_addr"}, write_address, a);
    chk({tag, "_data"}, data_write, d);
    chk({tag, "_os"}, {31'b0, write_os}, {31'b0, os});
  endtask

  // Completes a load whose last strobe is visible now; expects the done pulse.
  task automatic end_load(input string tag, input logic [31:0] sum);
`ifdef LOADER_CHECKSUM_EN
    send_word(sum);
`else
    step();
    if (sum == 32'hFFFF_FFFF) chk("never", 32'd0, {31'b0, done});
`endif
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
    step();
    chk({tag, "_done_clr"}, {31'b0, done}, 32'd0);
    chk({tag, "_busy_clr"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; target_os = 1'b0; base_addr = '0; word_count = '0;
    abort = 1'b0; byte_in = '0; byte_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    chk("rst_gravar", {31'b0, gravar_D}, 32'd0);
    chk("rst_write_os", {31'b0, write_os}, 32'd0);
    chk("rst_addr", write_address, 32'd0);
    chk("rst_data", data_write, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    byte_valid = 1'b1;
    byte_in = 8'h55;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_ready", {31'b0, byte_ready}, 32'd0);
    end
    byte_valid = 1'b0;
    chk("idle_no_write", nwr, 32'd0);

    // Two-word load into the program bank
    do_start(1'b0, 32'd16, 12'd2);
    chk("a_busy", {31'b0, busy}, 32'd1);
    chk("a_ready", {31'b0, byte_ready}, 32'd1);
    send_word(32'h1234_5678);
    chk_strobe("a_w0", 32'd16, 32'h1234_5678, 1'b0);
    chk("a_ready_in_write", {31'b0, byte_ready}, 32'd0);
    send_word(32'h9ABC_DEF0);
    chk_strobe("a_w1", 32'd17, 32'h9ABC_DEF0, 1'b0);
    end_load("a", 32'hACF1_3568);
    chk("a_nwr", nwr, 32'd2);
    chk("a_ndone", ndone, 32'd1);

    // Out-of-range request is rejected
    wr0 = nwr;
    do_start(1'b1, 32'd2047, 12'd3);
    chk("e_error", {31'b0, error}, 32'd1);
    chk("e_busy", {31'b0, busy}, 32'd0);
    step(); step(); step();
    chk("e_busy_hold", {31'b0, busy}, 32'd0);
    chk("e_error_hold", {31'b0, error}, 32'd1);
    chk("e_no_write", nwr, wr0);

    // Range boundary: last address MEM_DEPTH-1, clears error, OS bank
    do_start(1'b1, 32'd2047, 12'd2);
    chk("b_error_clr", {31'b0, error}, 32'd0);
    chk("b_busy", {31'b0, busy}, 32'd1);
    send_word(32'h0102_0304);
    chk_strobe("b_w0", 32'd2047, 32'h0102_0304, 1'b1);
    send_word(32'h0506_0708);
    chk_strobe("b_w1", 32'd2048, 32'h0506_0708, 1'b1);
    end_load("b", 32'h0608_0A0C);
    chk("b_os_hold", {31'b0, write_os}, 32'd1);

    // Toggling byte_valid, one-word load
    wr0 = nwr;
    do_start(1'b0, 32'd100, 12'd1);
    byte_in = 8'hAA; byte_valid = 1'b1; step(); byte_valid = 1'b0; step();
    byte_in = 8'hBB; byte_valid = 1'b1; step(); byte_valid = 1'b0; step();
    byte_in = 8'hCC; byte_valid = 1'b1; step(); byte_valid = 1'b0; step();
    chk("t_no_early_write", nwr, wr0);
    byte_in = 8'hDD; byte_valid = 1'b1; step(); byte_valid = 1'b0;
    chk_strobe("t_w0", 32'd100, 32'hAABB_CCDD, 1'b0);
    end_load("t", 32'hAABB_CCDD);
    chk("t_one_write", nwr - wr0, 32'd1);

    // Abort mid-word
    wr0 = nwr;
    dn0 = ndone;
    do_start(1'b0, 32'd200, 12'd3);
    send_word(32'h1111_2222);
    chk_strobe("x_w0", 32'd200, 32'h1111_2222, 1'b0);
    send_byte(8'h33);
    send_byte(8'h44);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("x_busy", {31'b0, busy}, 32'd0);
    chk("x_ready", {31'b0, byte_ready}, 32'd0);
    chk("x_error", {31'b0, error}, 32'd0);
    chk("x_done", {31'b0, done}, 32'd0);
    byte_valid = 1'b1; byte_in = 8'h55;
    step(); step(); step();
    byte_valid = 1'b0;
    chk("x_writes", nwr - wr0, 32'd1);
    chk("x_no_done", ndone - dn0, 32'd0);

    // Zero-length load
    do_start(1'b0, 32'd5, 12'd0);
`ifdef LOADER_CHECKSUM_EN
    chk("z_busy", {31'b0, busy}, 32'd1);
    send_word(32'h0);
`endif
    chk("z_done", {31'b0, done}, 32'd1);
    step();
    chk("z_idle", {31'b0, busy}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum wraps to zero: match
    do_start(1'b0, 32'd300, 12'd2);
    send_word(32'h0000_0001);
    chk_strobe("c_w0", 32'd300, 32'h0000_0001, 1'b0);
    send_word(32'hFFFF_FFFF);
    chk_strobe("c_w1", 32'd301, 32'hFFFF_FFFF, 1'b0);
    end_load("c", 32'h0000_0000);
    // Checksum mismatch
    wr0 = nwr;
    dn0 = ndone;
    do_start(1'b0, 32'd300, 12'd2);
    send_word(32'h0000_0001);
    send_word(32'hFFFF_FFFF);
    send_word(32'h0000_0001);
    chk("m_error", {31'b0, error}, 32'd1);
    chk("m_busy", {31'b0, busy}, 32'd0);
    step();
    chk("m_writes", nwr - wr0, 32'd2);
    chk("m_no_done", ndone - dn0, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Byte-stream program loader sitting directly upstream of the instruction memory. It receives a stream of bytes over a valid/ready handshake and packs each group of four into a 32-bit instruction word. It then issues single-cycle write strobes (gravar_D, write_os, write_address, data_write) into either the OS or the program instruction bank. The kernel uses it to install the OS image at boot and to swap user programs in at run time.

Parameters:
MEM_DEPTH, 2049, number of words per instruction bank; valid addresses are 0..MEM_DEPTH-1
CNT_W, 12, width of the word-count input

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a load; honoured only in IDLE
target_os  input  1  bank select latched at start: 1 = OS bank, 0 = program bank
base_addr  input  32  first word address, latched at start
word_count  input  CNT_W  number of 32-bit words to load, latched at start
abort  input  1  cancel the load in progress
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle
gravar_D  output  1  instruction-memory write strobe
write_os  output  1  bank select to instruction memory
write_address  output  32  word address of the write
data_write  output  32  instruction word to write
busy  output  1  high from accepted start until return to IDLE
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Reset (synchronous, active-high): state = IDLE. All outputs 0: byte_ready, gravar_D, write_os, write_address, data_write, busy, done, error. Byte counter, word index and shift register are also cleared.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - start=1 latches target_os, base_addr and word_count, sets index=0 and byte counter=0, and clears error.
  - If word_count=0: go to DONE.
  - Else if base_addr+word_count > MEM_DEPTH (computed at 33 bits, so no wrap): set error=1, stay in IDLE, issue no writes.
  - Otherwise: go to RECV.
  - start is ignored in every state except IDLE.
- RECV:
  - byte_ready=1. A byte is accepted when byte_valid && byte_ready.
  - Packing is big-endian: shift = {shift[23:0], byte_in}, so the first byte becomes bits 31:24.
  - Acceptance of the 4th byte moves the FSM to WRITE on the next edge.
- WRITE (exactly one cycle):
  - gravar_D=1, byte_ready=0.
  - write_address = base_addr + index; data_write = packed word.
  - Next state: index+1 == word_count goes to DONE; otherwise index increments and the FSM returns to RECV.
- Latency: gravar_D is high in the cycle immediately after the 4th byte handshake. Sustained throughput is one word per 5 cycles.
- write_os drives the latched target for the whole load; it holds its value in IDLE.
- write_address and data_write hold their last values outside WRITE.
- DONE: done=1 for one cycle, then IDLE. busy=1 in RECV, WRITE and DONE.
- abort:
  - In RECV or WRITE, abort takes priority and the FSM goes to IDLE on the next edge.
  - A WRITE cycle coinciding with abort still completes its strobe (the strobe is registered with the state).
  - A partially packed word is discarded. error is not set and done is not pulsed.
- Simultaneous reset and any other input: reset wins.
- The last address written is at most MEM_DEPTH-1; the address never wraps.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - After the last data word, the loader receives 4 extra bytes (big-endian) carrying the expected checksum: the sum of all data words mod 2^32.
  - No memory write is issued for the checksum word.
  - Match: pulse done. Mismatch: set error=1 with no done pulse, then return to IDLE.
  - With word_count=0 the checksum word is still received and must equal 0.
- Undefined: no checksum phase; behaviour is exactly as described above.

Test Plan:
- Reset then idle: all outputs 0; byte_ready=0 with byte_valid=1 held for 10 cycles.
- start, target_os=0, base_addr=16, word_count=2, bytes 12 34 56 78 9A BC DE F0 -> two strobes: (addr 16, 0x12345678, write_os=0) and (addr 17, 0x9ABCDEF0); done pulses once, 1 cycle after the second strobe.
- start, target_os=1, base_addr=2047, word_count=3 -> error=1, no gravar_D, busy stays 0. A following valid start clears error.
- byte_valid toggling every other cycle during a 1-word load of AA BB CC DD -> single write of 0xAABBCCDD; gravar_D high exactly one cycle.
- abort after 2 bytes of the second word of a 3-word load -> only one write has occurred; IDLE next cycle; error=0; done=0.
- LOADER_CHECKSUM_EN: words 0x00000001 and 0xFFFFFFFF with checksum 0x00000000 -> done. The same words with checksum 0x00000001 -> error=1, 2 writes, no done.
